// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Bus widths, FSM states, grant owner and tie-break helper.
package mem_port_arbiter_pkg;

  localparam int ADDR_BUS    = 32;
  localparam int DATA_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DATA,
    ST_RESP
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_e;

  // On a tie the port not served last wins.
  function automatic gnt_e pick_port(
    input logic f,
    input logic d,
    input gnt_e last
  );
    if (f && d)
      return (last == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    return d ? GNT_DATA : GNT_FETCH;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Bus wait watchdog for mem_port_arbiter.
// Only built when ARB_BUS_TIMEOUT_EN is defined.
`ifdef ARB_BUS_TIMEOUT_EN
module mem_arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic busy_i,
  input  logic ready_i,
  output logic expire_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count waiting bus cycles, restart on every grant.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (busy_i && !ready_i)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expire_o = busy_i && !ready_i &&
                    (cnt_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory bus between fetch and data ports.
// ARB_BUS_TIMEOUT_EN enables the bus wait watchdog and bus_err.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_en,
  input  logic [ADDR_BUS-1:0]    if_addr,
  output logic [DATA_BUS-1:0]    if_rdata,
  output logic                   if_valid,
  output logic                   stall_if,
  input  logic                   mem_en,
  input  logic [MEM_SEL_BUS-1:0] mem_wen,
  input  logic [ADDR_BUS-1:0]    mem_addr,
  input  logic [DATA_BUS-1:0]    mem_wdata,
  output logic [DATA_BUS-1:0]    mem_rdata,
  output logic                   mem_valid,
  output logic                   stall_mem,
  output logic                   bus_req,
  output logic [MEM_SEL_BUS-1:0] bus_wen,
  output logic [ADDR_BUS-1:0]    bus_addr,
  output logic [DATA_BUS-1:0]    bus_wdata,
  input  logic [DATA_BUS-1:0]    bus_rdata,
  input  logic                   bus_ready,
  output logic                   bus_err
);

  arb_state_e             state_q;
  gnt_e                   last_q;
  logic                   req_q;
  logic [MEM_SEL_BUS-1:0] wen_q;
  logic [ADDR_BUS-1:0]    addr_q;
  logic [DATA_BUS-1:0]    wdata_q;
  logic [DATA_BUS-1:0]    if_rdata_q, mem_rdata_q;
  logic                   if_valid_q, mem_valid_q;

`ifdef ARB_BUS_TIMEOUT_EN
  logic err_q;
  logic expire;
  logic grant;
  logic busy;

  assign grant = (state_q == ST_IDLE) && (if_en || mem_en);
  assign busy  = (state_q == ST_FETCH) || (state_q == ST_DATA);

  mem_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (grant),
    .busy_i   (busy),
    .ready_i  (bus_ready),
    .expire_o (expire)
  );

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Transfer sequencer with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      last_q      <= GNT_FETCH;
      req_q       <= 1'b0;
      wen_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
`ifdef ARB_BUS_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (if_en || mem_en) begin
            req_q <= 1'b1;
            if (pick_port(if_en, mem_en, last_q) == GNT_DATA) begin
              addr_q  <= mem_addr;
              wen_q   <= mem_wen;
              wdata_q <= mem_wdata;
              state_q <= ST_DATA;
            end else begin
              addr_q  <= if_addr;
              wen_q   <= '0;
              wdata_q <= '0;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (bus_ready) begin
            if_rdata_q <= bus_rdata;
            if_valid_q <= 1'b1;
            req_q      <= 1'b0;
            state_q    <= ST_RESP;
          end
`ifdef ARB_BUS_TIMEOUT_EN
          else if (expire) begin
            if_rdata_q <= '0;
            if_valid_q <= 1'b1;
            err_q      <= 1'b1;
            req_q      <= 1'b0;
            state_q    <= ST_RESP;
          end
`endif
        end
        ST_DATA: begin
          if (bus_ready) begin
            mem_rdata_q <= (|wen_q) ? '0 : bus_rdata;
            mem_valid_q <= 1'b1;
            req_q       <= 1'b0;
            state_q     <= ST_RESP;
          end
`ifdef ARB_BUS_TIMEOUT_EN
          else if (expire) begin
            mem_rdata_q <= '0;
            mem_valid_q <= 1'b1;
            err_q       <= 1'b1;
            req_q       <= 1'b0;
            state_q     <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          last_q      <= if_valid_q ? GNT_FETCH : GNT_DATA;
          if_valid_q  <= 1'b0;
          mem_valid_q <= 1'b0;
`ifdef ARB_BUS_TIMEOUT_EN
          err_q       <= 1'b0;
`endif
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_req   = req_q;
  assign bus_wen   = wen_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_valid = mem_valid_q;
  assign stall_if  = if_en && !if_valid_q;
  assign stall_mem = mem_en && !mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transfer-level model.
// Honours ARB_BUS_TIMEOUT_EN for the watchdog expectations.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_en = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, stall_if;
  logic        mem_en = 1'b0;
  logic [3:0]  mem_wen = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_valid, stall_mem;
  logic        bus_req;
  logic [3:0]  bus_wen;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_en     (if_en),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .stall_if  (stall_if),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .stall_mem (stall_mem),
    .bus_req   (bus_req),
    .bus_wen   (bus_wen),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .bus_err   (bus_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transfer-level model: who owns the bus, what it should show,
  // and the response each port should see next cycle.
  int          m_ph;       // 0 free, 1 fetch busy, 2 data busy, 3 resp
  bit          m_last_d;   // last served port was data
  bit          m_wr;
  int          m_wait;
  logic        e_req, e_ifv, e_memv, e_err;
  logic [3:0]  e_wen;
  logic [31:0] e_addr, e_wdata, e_ifr, e_memr;

  task automatic m_reset();
    m_ph = 0; m_last_d = 0; m_wr = 0; m_wait = 0;
    e_req = 0; e_ifv = 0; e_memv = 0; e_err = 0;
    e_wen = '0; e_addr = '0; e_wdata = '0;
    e_ifr = '0; e_memr = '0;
  endtask

  task automatic m_eval();
    bit take_d;
    if (!rst) begin
      m_reset();
      return;
    end
    case (m_ph)
      0: if (if_en || mem_en) begin
        take_d = mem_en && (!if_en || !m_last_d);
        if (take_d) begin
          e_addr = mem_addr; e_wen = mem_wen;
          e_wdata = mem_wdata; m_wr = |mem_wen;
          m_ph = 2;
        end else begin
          e_addr = if_addr; e_wen = '0; e_wdata = '0;
          m_ph = 1;
        end
        e_req = 1; m_wait = 0;
      end
      1, 2: begin
        if (bus_ready) begin
          e_req = 0;
          if (m_ph == 1) begin
            e_ifv = 1; e_ifr = bus_rdata;
          end else begin
            e_memv = 1; e_memr = m_wr ? 32'd0 : bus_rdata;
          end
          m_ph = 3;
        end else begin
          m_wait++;
`ifdef ARB_BUS_TIMEOUT_EN
          if (m_wait == TO) begin
            e_req = 0; e_err = 1;
            if (m_ph == 1) begin e_ifv = 1; e_ifr = 0; end
            else begin e_memv = 1; e_memr = 0; end
            m_ph = 3;
          end
`endif
        end
      end
      default: begin
        m_last_d = e_memv;
        e_ifv = 0; e_memv = 0; e_err = 0;
        m_ph = 0;
      end
    endcase
  endtask

  // Requester / bus behaviour knobs.
  int f_rate = 0, d_rate = 0, ready_mode = 0, wcnt = 0;
  bit f_adv = 0, d_adv = 0;

  task automatic new_fetch();
    if_en = 1; if_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_data();
    mem_en = 1;
    mem_addr = $urandom & 32'hFFFF_FFFC;
    mem_wen = $urandom_range(1) ? 4'($urandom) : 4'd0;
    mem_wdata = $urandom;
  endtask

  // Requesters advance one edge after their valid pulse.
  task automatic auto_drive();
    if (f_adv) begin
      if ($urandom_range(99) < f_rate) new_fetch();
      else if_en = 0;
    end else if (!if_en && f_rate > 0 &&
                 $urandom_range(99) < f_rate)
      new_fetch();
    if (d_adv) begin
      if ($urandom_range(99) < d_rate) new_data();
      else mem_en = 0;
    end else if (!mem_en && d_rate > 0 &&
                 $urandom_range(99) < d_rate)
      new_data();
    f_adv = e_ifv && if_en;
    d_adv = e_memv && mem_en;
    if (e_req) wcnt++; else wcnt = 0;
    case (ready_mode)
      0: bus_ready = 1'($urandom_range(1));
      1: bus_ready = 1'b1;
      2: bus_ready = 1'b0;
      default: bus_ready = (wcnt >= 6);
    endcase
    bus_rdata = $urandom;
  endtask

  task automatic cyc();
    #1;
    chk("stall_if", stall_if, if_en && !e_ifv);
    chk("stall_mem", stall_mem, mem_en && !e_memv);
    m_eval();
    @(posedge clk);
    #1;
    chk("bus_req", bus_req, e_req);
    chk("bus_addr", bus_addr, e_addr);
    chk("bus_wen", bus_wen, e_wen);
    chk("bus_wdata", bus_wdata, e_wdata);
    chk("if_valid", if_valid, e_ifv);
    chk("mem_valid", mem_valid, e_memv);
    chk("if_rdata", if_rdata, e_ifr);
    chk("mem_rdata", mem_rdata, e_memr);
    chk("bus_err", bus_err, e_err);
    auto_drive();
  endtask

  task automatic drain();
    int k;
    f_rate = 0; d_rate = 0; ready_mode = 1;
    for (k = 0; k < 60; k++) begin
      if (!if_en && !mem_en && m_ph == 0) break;
      cyc();
    end
    chk("drain_idle", {31'd0, if_en | mem_en}, 32'd0);
  endtask

  int npulse;

  initial begin
    m_reset();
    repeat (3) cyc();

    // Boot fetch on a zero-wait bus.
    rst = 1; if_en = 1; if_addr = 32'hBFC0_0000;
    ready_mode = 1; bus_ready = 1;
    repeat (6) cyc();
    drain();

    // Continuous ties: data first, then alternation.
    if_en = 1; if_addr = 32'h0000_0100;
    mem_en = 1; mem_wen = 0; mem_addr = 32'h8000_0010;
    f_rate = 100; d_rate = 100; ready_mode = 1;
    repeat (14) cyc();
    drain();

    // Store held through a five-cycle bus wait.
    mem_en = 1; mem_wen = 4'b0011;
    mem_addr = 32'h8000_0020; mem_wdata = 32'hCAFE_F00D;
    ready_mode = 3; bus_ready = 0;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (mem_valid) npulse++;
    end
    chk("store_pulses", npulse, 1);
    drain();

    // Reset dropped into an open data transfer.
    mem_en = 1; mem_wen = 0; mem_addr = 32'h8000_0030;
    ready_mode = 2; bus_ready = 0;
    repeat (3) cyc();
    #2 rst = 0;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    m_reset();
    repeat (2) cyc();
    rst = 1; if_en = 1; if_addr = 32'h0000_0200;
    ready_mode = 1;
    repeat (8) cyc();
    drain();

    // Bus that never answers.
    if_en = 1; if_addr = 32'h0000_0300;
    ready_mode = 2; bus_ready = 0;
    repeat (20) cyc();
`ifndef ARB_BUS_TIMEOUT_EN
    chk("perm_stall", stall_if, 1);
`endif
    rst = 0;
    cyc();
    rst = 1; if_en = 0;
    repeat (2) cyc();

    // Random traffic and latency.
    f_rate = 60; d_rate = 60; ready_mode = 0;
    repeat (600) cyc();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer/arbiter that shares one single-port, variable-latency memory bus between the IF-stage fetch port (driven from the program counter's ROM control outputs) and the MEM-stage data port. It serialises requests, runs one bus transfer at a time under a req/ready handshake, returns registered read data with a one-cycle valid pulse, and produces the stall signals that freeze the PC and the MEM stage while their access is outstanding. It sits between the core's IF/MEM stages and the external memory interface.

## Interface
- TIMEOUT_CYCLES, 255: bus wait limit in cycles (used only with the timeout feature).
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- if_en  input  1  fetch request (from PC rom_en).
- if_addr  input  32  fetch address (from PC rom_addr).
- if_rdata  output  32  fetched instruction, registered.
- if_valid  output  1  one-cycle pulse, if_rdata valid.
- stall_if  output  1  if_en && !if_valid, to PC stall input.
- mem_en  input  1  data request.
- mem_wen  input  4  byte write enables; 0 = read.
- mem_addr  input  32  data address.
- mem_wdata  input  32  store data.
- mem_rdata  output  32  load data, registered.
- mem_valid  output  1  one-cycle pulse, mem_rdata valid / store done.
- stall_mem  output  1  mem_en && !mem_valid.
- bus_req  output  1  transfer request, registered.
- bus_wen  output  4  byte write enables, registered.
- bus_addr  output  32  registered.
- bus_wdata  output  32  registered.
- bus_rdata  input  32  read data, sampled when bus_req && bus_ready.
- bus_ready  input  1  transfer completes this cycle.
- bus_err  output  1  one-cycle pulse with a valid that ended by timeout.

## Operation
- States: IDLE, FETCH, DATA, RESP.
- IDLE: arbitrate. Only one pending: grant it. Both pending: grant the one not granted last (last_grant flag; reset value FETCH, so data wins the first tie). Grant latches addr/wen/wdata into bus_* regs, sets bus_req, moves to FETCH or DATA.
- FETCH: bus_wen=0 and bus_wdata=0 always.
- FETCH/DATA: hold bus_req and all bus_* stable until bus_ready=1. On that cycle, capture bus_rdata into if_rdata or mem_rdata (mem_rdata=0 for writes), drop bus_req, go RESP.
- RESP: assert the matching valid for exactly this cycle, update last_grant, go IDLE. No arbitration in RESP, so a requester still holding its old request is never relaunched.
- Requesters hold en/addr/data stable while stalled. If a request drops mid-transfer, the transfer still completes and the valid pulse still fires. Requesters ignore the pulse.
- Reset (any state, any cycle): state=IDLE, bus_req=0, bus_wen=0, bus_addr=0, bus_wdata=0, if_rdata=0, mem_rdata=0, if_valid=0, mem_valid=0, bus_err=0, last_grant=FETCH, timeout counter=0. An in-flight bus transfer is abandoned.

## Timing
- Grant edge: bus_req rises on the edge after the IDLE cycle that sees the request.
- bus_ready at cycle t gives valid at t+1 and IDLE at t+2.
- With a zero-wait bus, minimum spacing is 3 cycles per transfer: IDLE, FETCH/DATA, RESP.
- stall_* is combinational from inputs and registered valid. It is low in the valid cycle, so the requester advances at the next edge.
- bus_ready while bus_req=0 is ignored.

## Configuration
- ARB_BUS_TIMEOUT_EN defined:
  - A counter increments on each FETCH/DATA cycle with bus_ready=0. It clears on grant.
  - When the counter reaches TIMEOUT_CYCLES, the transfer is aborted: bus_req=0, rdata=0, go RESP. bus_err pulses with the valid.
- ARB_BUS_TIMEOUT_EN undefined: the arbiter waits indefinitely. bus_err is tied 0 and the port is kept.

## Structure
- State encodings and the TIMEOUT default go in a new shared header arbdef.v, alongside bus.v (ADDR_BUS, DATA_BUS, MEM_SEL_BUS widths are reused).
- One sub-module, mem_arb_watchdog: the timeout counter. It is instantiated only under ARB_BUS_TIMEOUT_EN.

## Test plan
- Reset release, if_en=1 with if_addr=0xBFC00000, bus_ready=1 each cycle: bus_req with bus_addr=0xBFC00000 one edge later; if_valid one cycle after ready with if_rdata=bus_rdata; stall_if low in that cycle.
- if_en and mem_en (load, 0x80000010) rise together: DATA granted first, FETCH next; second tie goes to the alternate port.
- Store with mem_wen=4'b0011 and bus_ready delayed 5 cycles: bus_* stable for all 6 cycles; mem_valid pulses once; mem_rdata=0; stall_mem high for the whole wait.
- Assert rst mid-DATA: bus_req and all valids drop immediately and asynchronously; after release, first tie goes to data.
- Timeout (macro on, TIMEOUT_CYCLES=8) with bus_ready never asserted: abort after 8 wait cycles; valid and bus_err pulse together; rdata=0.
- Timeout (macro off): same stimulus produces a permanent stall and bus_err=0 throughout.
